cdb_arbiter: RTL and testbench

Round-robin arbiter that shares one result broadcast bus between the execution unit wrappers (CMP, ALU, MUL, …). Each unit presents a ready/valid result carrying its reservation-station ID and value. The arbiter picks one result per cycle and registers it onto the bus. The bus feeds the reservation stations' `update_op_*` inputs and the commit logic.

---
 rtl/cdb_arbiter.sv | 93 +++++++++
 tb/tb_cdb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared common data bus.
// One registered broadcast slot with ready/valid on both sides.
module cdb_arbiter #(
  parameter int NUM_UNITS   = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int DATA_WIDTH  = 32,
  localparam int IW = $clog2(NUM_UNITS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [0:NUM_UNITS-1]              unit_valid,
  output logic [0:NUM_UNITS-1]              unit_ready,
  input  logic [0:NUM_UNITS*RS_ID_WIDTH-1]  unit_rs_id,
  input  logic [0:NUM_UNITS*DATA_WIDTH-1]   unit_value,
  output logic                              cdb_valid,
  input  logic                              cdb_ready,
  output logic [0:RS_ID_WIDTH-1]            cdb_rs_id,
  output logic [0:DATA_WIDTH-1]             cdb_value,
  output logic [0:IW-1]                     cdb_unit
);

  localparam logic [IW:0]   NU   = (IW+1)'(NUM_UNITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_UNITS - 1);

  logic                   r_cdb_valid;
  logic [0:RS_ID_WIDTH-1] r_cdb_rs_id;
  logic [0:DATA_WIDTH-1]  r_cdb_value;
  logic [IW-1:0]          r_cdb_unit;
  logic [IW-1:0]          r_prio;

  logic                   w_load;
  logic                   w_found;
  logic                   w_grant;
  logic [IW:0]            w_sum;
  logic [IW-1:0]          w_gnt_idx;
  logic [0:RS_ID_WIDTH-1] w_rs_id;
  logic [0:DATA_WIDTH-1]  w_value;

  assign w_load  = !r_cdb_valid || cdb_ready;
  assign w_grant = w_load && w_found && !rst;

  // Scan from r_prio upward, wrapping; first valid unit wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_sum = {1'b0, r_prio} + (IW+1)'(k);
      if (w_sum >= NU) w_sum = w_sum - NU;
      if (!w_found && unit_valid[w_sum[IW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_rs_id    = '0;
    w_value    = '0;
    unit_ready = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_gnt_idx == IW'(i)) begin
        w_rs_id       = unit_rs_id[i*RS_ID_WIDTH +: RS_ID_WIDTH];
        w_value       = unit_value[i*DATA_WIDTH +: DATA_WIDTH];
        unit_ready[i] = w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_rs_id <= '0;
      r_cdb_value <= '0;
      r_cdb_unit  <= '0;
      r_prio      <= '0;
    end else if (w_load) begin
      r_cdb_valid <= w_grant;
      if (w_grant) begin
        r_cdb_rs_id <= w_rs_id;
        r_cdb_value <= w_value;
        r_cdb_unit  <= w_gnt_idx;
        r_prio      <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_rs_id = r_cdb_rs_id;
  assign cdb_value = r_cdb_value;
  assign cdb_unit  = r_cdb_unit;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts,
// a monitor pops them whenever the bus is consumed.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic [0:3]   unit_valid;
  logic [0:3]   unit_ready;
  logic [0:19]  unit_rs_id;
  logic [0:127] unit_value;
  logic         cdb_valid;
  logic         cdb_ready;
  logic [0:4]   cdb_rs_id;
  logic [0:31]  cdb_value;
  logic [0:1]   cdb_unit;

  typedef struct {
    int          u;
    logic [4:0]  id;
    logic [31:0] v;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  m_id[4];
  logic [31:0] m_val[4];
  int          total = 0;
  int          bad   = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_rs_id(unit_rs_id), .unit_value(unit_value),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rs_id(cdb_rs_id), .cdb_value(cdb_value),
    .cdb_unit(cdb_unit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set_unit(input int i, input logic [4:0] id,
                          input logic [31:0] v);
    unit_rs_id[i*5 +: 5]  = id;
    unit_value[i*32 +: 32] = v;
    m_id[i]  = id;
    m_val[i] = v;
  endtask

  task automatic expect_grant(input string nm, input int u,
                              input bit push);
    logic [0:3] oh;
    exp_t e;
    oh    = '0;
    oh[u] = 1'b1;
    chk(nm, unit_ready, oh);
    if (push) begin
      e.u  = u;
      e.id = m_id[u];
      e.v  = m_val[u];
      q.push_back(e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed broadcast must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cdb_valid && cdb_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_bcast", {62'd0, cdb_unit}, 64'hFFFF);
        end else begin
          e = q.pop_front();
          chk("bcast_unit", cdb_unit, e.u);
          chk("bcast_id", cdb_rs_id, e.id);
          chk("bcast_val", cdb_value, e.v);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    unit_valid = 4'b1111;
    cdb_ready  = 1'b1;
    for (int i = 0; i < 4; i++)
      set_unit(i, 5'(10 + i), 32'hA500_0000 + i);

    // reset
    @(negedge clk);
    chk("rst_ready", unit_ready, 4'b0000);
    @(negedge clk);
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_id", cdb_rs_id, 5'd0);
    chk("rst_val", cdb_value, 32'd0);
    chk("rst_unit", cdb_unit, 2'd0);

    // round-robin, all valid: 0,1,2,3,0,1
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expect_grant("rr_ready", k % 4, 1'b1);
      if (k > 0) chk("rr_no_bubble", cdb_valid, 1'b1);
      nxt();
    end

    // single request from unit 2, back-to-back with last rr grant
    unit_valid = 4'b0010;
    set_unit(2, 5'd9, 32'hDEADBEEF);
    @(negedge clk);
    expect_grant("single_ready", 2, 1'b1);
    nxt();
    unit_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_unit", cdb_unit, 2'd2);
    nxt();
    @(negedge clk);
    chk("single_drain", cdb_valid, 1'b0);

    // wrap-around: prio=3, units 0 and 3 valid
    nxt();
    unit_valid = 4'b1001;
    @(negedge clk);
    expect_grant("wrap_first", 3, 1'b1);
    nxt();
    unit_valid = 4'b1000;
    @(negedge clk);
    expect_grant("wrap_second", 0, 1'b1);
    nxt();
    unit_valid = 4'b0000;
    @(negedge clk);
    nxt();

    // stall: unit 1 on bus, consumer not ready, unit 3 waiting
    unit_valid = 4'b0100;
    @(negedge clk);
    expect_grant("stall_load", 1, 1'b1);
    nxt();
    unit_valid = 4'b0001;
    cdb_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", unit_ready, 4'b0000);
      chk("stall_valid", cdb_valid, 1'b1);
      chk("stall_unit", cdb_unit, 2'd1);
      chk("stall_id", cdb_rs_id, m_id[1]);
      nxt();
    end
    cdb_ready = 1'b1;
    @(negedge clk);
    expect_grant("stall_release", 3, 1'b1);
    nxt();
    unit_valid = 4'b0000;
    @(negedge clk);
    chk("stall_next_unit", cdb_unit, 2'd3);
    nxt();

    // reset mid-stall: pending unit 2 broadcast is dropped
    unit_valid = 4'b0010;
    @(negedge clk);
    expect_grant("mid_load", 2, 1'b0);
    nxt();
    unit_valid = 4'b0000;
    cdb_ready  = 1'b0;
    @(negedge clk);
    chk("mid_stalled", cdb_valid, 1'b1);
    nxt();
    rst        = 1'b1;
    unit_valid = 4'b0101;
    @(negedge clk);
    chk("mid_rst_ready", unit_ready, 4'b0000);
    nxt();
    rst       = 1'b0;
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("mid_dropped", cdb_valid, 1'b0);
    expect_grant("mid_prio0", 1, 1'b1);
    nxt();
    unit_valid = 4'b0000;
    @(negedge clk);
    chk("mid_unit", cdb_unit, 2'd1);
    nxt();
    @(negedge clk);
    chk("mid_no_dup", cdb_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
